// File: rtl/e203_dtcm_icb_filler.sv
// e203_dtcm_icb_filler: ICB initiator that fills a range of DTCM words with a
// fixed or incrementing pattern. When built with E203_DTCM_FILLER_VERIFY_EN it
// can also read the range back and count mismatches.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, op                   request pulse (IDLE only); 0 = fill, 1 = read-verify
//   base_addr, word_cnt         first byte address (bits [1:0] ignored), word count
//   pattern, incr_en            first data word; word i = pattern + i when incr_en
//   busy, done, err             status: busy span, done pulse, sticky response error
//   mismatch_cnt                read-verify mismatch count (saturating)
//   icb_cmd_*                   ICB command channel (initiator side)
//   icb_rsp_*                   ICB response channel (initiator side)
//
// Optional feature macro: E203_DTCM_FILLER_VERIFY_EN (read-verify support).
module e203_dtcm_icb_filler #(
  parameter int unsigned AW       = 16,
  parameter int unsigned CNT_W    = 14,
  parameter int unsigned OUTS_NUM = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  input  logic [31:0]      pattern,
  input  logic             incr_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             icb_cmd_valid,
  input  logic             icb_cmd_ready,
  output logic [AW-1:0]    icb_cmd_addr,
  output logic             icb_cmd_read,
  output logic [31:0]      icb_cmd_wdata,
  output logic [3:0]       icb_cmd_wmask,
  input  logic             icb_rsp_valid,
  output logic             icb_rsp_ready,
  input  logic             icb_rsp_err,
  input  logic [31:0]      icb_rsp_rdata
);

  localparam int unsigned OW = $clog2(OUTS_NUM + 1);
  localparam logic [OW-1:0] OUTS_MAX = OW'(OUTS_NUM);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [OW-1:0]    outs_cnt;
  logic [OW-1:0]    outs_nxt;
  logic [CNT_W-1:0] cnt_l;
  logic [CNT_W-1:0] cidx;
  logic             incr_l;
  logic             cmd_hs;
  logic             rsp_hs;
  logic             last_cmd;
  logic             rd_op;
  logic             unused_ok;

  // Responses are always accepted; one with nothing outstanding is dropped.
  assign icb_rsp_ready = 1'b1;
  assign cmd_hs   = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hs   = icb_rsp_valid & icb_rsp_ready & (outs_cnt != '0);
  assign outs_nxt = outs_cnt + OW'(cmd_hs) - OW'(rsp_hs);
  assign last_cmd = (cidx == cnt_l - CNT_W'(1));

`ifdef E203_DTCM_FILLER_VERIFY_EN
  logic [31:0]      pattern_l;
  logic             op_l;
  logic [CNT_W-1:0] ridx;
  logic [31:0]      exp_data;

  assign rd_op     = op;
  assign exp_data  = pattern_l + (incr_l ? 32'(ridx) : 32'd0);
  assign unused_ok = ^base_addr[1:0];

  // Read-back compare; error responses carry no valid data and are skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_cnt <= '0;
      ridx         <= '0;
      pattern_l    <= '0;
      op_l         <= 1'b0;
    end else if (state == IDLE && start) begin
      mismatch_cnt <= '0;
      ridx         <= '0;
      pattern_l    <= pattern;
      op_l         <= op;
    end else if (rsp_hs) begin
      ridx <= ridx + CNT_W'(1);
      if (op_l && !icb_rsp_err && (icb_rsp_rdata != exp_data) && (mismatch_cnt != '1))
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end
`else
  assign rd_op        = 1'b0;
  assign mismatch_cnt = '0;
  assign unused_ok    = ^{op, icb_rsp_rdata, base_addr[1:0]};
`endif

  // Control FSM; command fields are registered and only advance on handshake,
  // so they stay stable while the target back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      icb_cmd_valid <= 1'b0;
      icb_cmd_addr  <= '0;
      icb_cmd_read  <= 1'b0;
      icb_cmd_wdata <= '0;
      icb_cmd_wmask <= '0;
      outs_cnt      <= '0;
      cnt_l         <= '0;
      cidx          <= '0;
      incr_l        <= 1'b0;
    end else begin
      outs_cnt <= outs_nxt;
      if (rsp_hs && icb_rsp_err) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            err  <= 1'b0;
            busy <= 1'b1;
            cidx <= '0;
            if (word_cnt != '0) begin
              state         <= ISSUE;
              cnt_l         <= word_cnt;
              incr_l        <= incr_en;
              icb_cmd_valid <= 1'b1;
              icb_cmd_addr  <= {base_addr[AW-1:2], 2'b00};
              icb_cmd_read  <= rd_op;
              icb_cmd_wdata <= rd_op ? 32'd0 : pattern;
              icb_cmd_wmask <= rd_op ? 4'h0 : 4'hF;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cmd_hs) begin
            cidx         <= cidx + CNT_W'(1);
            icb_cmd_addr <= icb_cmd_addr + AW'(4);
            if (!icb_cmd_read && incr_l) icb_cmd_wdata <= icb_cmd_wdata + 32'd1;
          end
          if (cmd_hs && last_cmd) begin
            state         <= DRAIN;
            icb_cmd_valid <= 1'b0;
          end else begin
            icb_cmd_valid <= (outs_nxt < OUTS_MAX);
          end
        end
        DRAIN: begin
          // Look at the post-update count so done follows the last response directly.
          if (outs_nxt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
